// File: rtl/vga_fb_write_arbiter.sv
// Write-port arbiter for the 80x60 VGA framebuffer: CPU pixel writes always win,
// and a rectangle-fill engine uses the port in every cycle the CPU leaves free.
module vga_fb_write_arbiter #(
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter int XW   = 7,
    parameter int YW   = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CPU_WE,
    input  logic [XW+YW-1:0] CPU_WA,
    input  logic [7:0]       CPU_WD,
    input  logic             FILL_START,
    input  logic [XW-1:0]    FILL_X0,
    input  logic [YW-1:0]    FILL_Y0,
    input  logic [XW-1:0]    FILL_X1,
    input  logic [YW-1:0]    FILL_Y1,
    input  logic [7:0]       FILL_COLOR,
    output logic             FILL_BUSY,
    output logic             FILL_DONE,
    output logic             FB_WE,
    output logic [XW+YW-1:0] FB_WA,
    output logic [7:0]       FB_WD
);

    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [XW-1:0]      r_x, w_x_nxt;
    logic [YW-1:0]      r_y, w_y_nxt;
    logic [XW-1:0]      r_x0, w_x0_nxt;
    logic [XW-1:0]      r_x1c, w_x1c_nxt;
    logic [YW-1:0]      r_y1c, w_y1c_nxt;
    logic [7:0]         r_color, w_color_nxt;
    logic               r_fb_we, w_fb_we_nxt;
    logic [XW+YW-1:0]   r_fb_wa, w_fb_wa_nxt;
    logic [7:0]         r_fb_wd, w_fb_wd_nxt;

    logic [XW-1:0]      w_x1_clamped;
    logic [YW-1:0]      w_y1_clamped;
    logic               w_last_pixel;

    assign w_x1_clamped = (FILL_X1 > X_MAX) ? X_MAX : FILL_X1;
    assign w_y1_clamped = (FILL_Y1 > Y_MAX) ? Y_MAX : FILL_Y1;
    assign w_last_pixel = (r_x == r_x1c) && (r_y == r_y1c);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_x0    <= '0;
            r_x1c   <= '0;
            r_y1c   <= '0;
            r_color <= '0;
            r_fb_we <= 1'b0;
            r_fb_wa <= '0;
            r_fb_wd <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_x0    <= w_x0_nxt;
            r_x1c   <= w_x1c_nxt;
            r_y1c   <= w_y1c_nxt;
            r_color <= w_color_nxt;
            r_fb_we <= w_fb_we_nxt;
            r_fb_wa <= w_fb_wa_nxt;
            r_fb_wd <= w_fb_wd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_x0_nxt    = r_x0;
        w_x1c_nxt   = r_x1c;
        w_y1c_nxt   = r_y1c;
        w_color_nxt = r_color;
        w_fb_we_nxt = 1'b0;
        w_fb_wa_nxt = r_fb_wa;
        w_fb_wd_nxt = r_fb_wd;

        // CPU owns the port whenever it strobes, regardless of fill state.
        if (CPU_WE) begin
            w_fb_we_nxt = 1'b1;
            w_fb_wa_nxt = CPU_WA;
            w_fb_wd_nxt = CPU_WD;
        end

        unique case (r_state)
            S_IDLE: begin
                if (FILL_START) begin
                    w_x0_nxt    = FILL_X0;
                    w_x1c_nxt   = w_x1_clamped;
                    w_y1c_nxt   = w_y1_clamped;
                    w_color_nxt = FILL_COLOR;
                    if ((FILL_X0 > w_x1_clamped) || (FILL_Y0 > w_y1_clamped)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_x_nxt     = FILL_X0;
                        w_y_nxt     = FILL_Y0;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (!CPU_WE) begin
                    w_fb_we_nxt = 1'b1;
                    w_fb_wa_nxt = {r_y, r_x};
                    w_fb_wd_nxt = r_color;
                    // Counters hold on the final pixel so y never passes the clamped bottom row.
                    if (w_last_pixel) begin
                        w_state_nxt = S_DONE;
                    end else if (r_x == r_x1c) begin
                        w_x_nxt = r_x0;
                        w_y_nxt = r_y + YW'(1);
                    end else begin
                        w_x_nxt = r_x + XW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign FILL_BUSY = (r_state != S_IDLE);
    assign FILL_DONE = (r_state == S_DONE);
    assign FB_WE     = r_fb_we;
    assign FB_WA     = r_fb_wa;
    assign FB_WD     = r_fb_wd;

endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Bench for vga_fb_write_arbiter: expected write streams come from a row-major
// pixel queue per rectangle, interleaved with randomly injected CPU writes.
module tb_vga_fb_write_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_WE;
    logic [12:0] CPU_WA;
    logic [7:0]  CPU_WD;
    logic        FILL_START;
    logic [6:0]  FILL_X0;
    logic [5:0]  FILL_Y0;
    logic [6:0]  FILL_X1;
    logic [5:0]  FILL_Y1;
    logic [7:0]  FILL_COLOR;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic        FB_WE;
    logic [12:0] FB_WA;
    logic [7:0]  FB_WD;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    vga_fb_write_arbiter #(.COLS(80), .ROWS(60), .XW(7), .YW(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CPU_WE     (CPU_WE),
        .CPU_WA     (CPU_WA),
        .CPU_WD     (CPU_WD),
        .FILL_START (FILL_START),
        .FILL_X0    (FILL_X0),
        .FILL_Y0    (FILL_Y0),
        .FILL_X1    (FILL_X1),
        .FILL_Y1    (FILL_Y1),
        .FILL_COLOR (FILL_COLOR),
        .FILL_BUSY  (FILL_BUSY),
        .FILL_DONE  (FILL_DONE),
        .FB_WE      (FB_WE),
        .FB_WA      (FB_WA),
        .FB_WD      (FB_WD)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] obs;
        RST = 1'b1; CPU_WE = 1'b1; CPU_WA = 13'h1ABC; CPU_WD = 8'h5A;
        FILL_START = 1'b0; FILL_X0 = '0; FILL_Y0 = '0; FILL_X1 = '0; FILL_Y1 = '0; FILL_COLOR = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            obs = {FB_WE, FB_WA, FB_WD, FILL_BUSY, FILL_DONE};
            n_total++;
            if (obs !== 24'h0) $display("FAIL reset cyc%0d got=%h exp=%h", c, obs, 24'h0);
            else n_pass++;
        end
        RST = 1'b0; CPU_WE = 1'b1; CPU_WA = 13'h0203; CPU_WD = 8'hE0;
        step();
        CPU_WE = 1'b0;
        obs = {FB_WE, FB_WA, FB_WD, FILL_BUSY, FILL_DONE};
        n_total++;
        if (obs !== {1'b1, 13'h0203, 8'hE0, 2'b00}) $display("FAIL cpu_write got=%h exp=%h", obs, {1'b1, 13'h0203, 8'hE0, 2'b00});
        else n_pass++;
        step();
        n_total++;
        if (FB_WE !== 1'b0) $display("FAIL cpu_write_one_cycle got=%b exp=0", FB_WE);
        else n_pass++;
    endtask

    task automatic test_cpu_back_to_back();
        logic [12:0] a;
        logic [7:0]  d;
        logic [23:0] obs, exp;
        for (int i = 0; i < 8; i++) begin
            a = 13'($urandom); d = 8'($urandom);
            CPU_WE = 1'b1; CPU_WA = a; CPU_WD = d;
            step();
            obs = {FB_WE, FB_WA, FB_WD, FILL_BUSY, FILL_DONE};
            exp = {1'b1, a, d, 2'b00};
            n_total++;
            if (obs !== exp) $display("FAIL cpu_b2b cyc%0d got=%h exp=%h", i, obs, exp);
            else n_pass++;
        end
        CPU_WE = 1'b0;
        step();
    endtask

    // Drives one fill and checks every cycle against a row-major pixel queue.
    // force_stall: loop cycle carrying a CPU write 0x0000/0xFF; abort_after: loop cycle asserting RST.
    task automatic run_fill(input string name, input int x0, input int y0, input int x1, input int y1,
                            input int color, input int stall_pct, input int force_stall, input int abort_after);
        int          x1c, y1c, i;
        bit          cpu;
        logic [12:0] q[$];
        logic [12:0] a;
        logic [12:0] wa;
        logic [7:0]  wd;
        logic [23:0] obs, exp;
        x1c = (x1 > 79) ? 79 : x1;
        y1c = (y1 > 59) ? 59 : y1;
        q.delete();
        for (int y = y0; y <= y1c; y++)
            for (int x = x0; x <= x1c; x++)
                q.push_back(13'(y * 128 + x));

        CPU_WE = 1'b0; FILL_START = 1'b1;
        FILL_X0 = 7'(x0); FILL_Y0 = 6'(y0); FILL_X1 = 7'(x1); FILL_Y1 = 6'(y1); FILL_COLOR = 8'(color);
        step();
        FILL_START = 1'b0;
        exp = {1'b0, 13'h0, 8'h0, 1'b1, (q.size() == 0)};
        obs = {FB_WE, FB_WE ? FB_WA : 13'h0, FB_WE ? FB_WD : 8'h0, FILL_BUSY, FILL_DONE};
        n_total++;
        if (obs !== exp) $display("FAIL %s start got=%h exp=%h", name, obs, exp);
        else n_pass++;

        i = 0;
        while (q.size() > 0 && i < 20000) begin
            if (i == abort_after) begin
                RST = 1'b1; CPU_WE = 1'b1; CPU_WA = 13'($urandom); CPU_WD = 8'($urandom);
                step();
                RST = 1'b0; CPU_WE = 1'b0;
                obs = {FB_WE, FB_WA, FB_WD, FILL_BUSY, FILL_DONE};
                n_total++;
                if (obs !== 24'h0) $display("FAIL %s abort got=%h exp=%h", name, obs, 24'h0);
                else n_pass++;
                return;
            end
            cpu = (i == force_stall) || (int'($urandom_range(99)) < stall_pct);
            wa = (i == force_stall) ? 13'h0000 : 13'($urandom);
            wd = (i == force_stall) ? 8'hFF : 8'($urandom);
            CPU_WE = cpu; CPU_WA = wa; CPU_WD = wd;
            // Mid-fill START pulses and new fill operands must be ignored.
            FILL_START = ($urandom_range(9) == 0);
            if (FILL_START) begin
                FILL_X0 = 7'($urandom); FILL_Y0 = 6'($urandom); FILL_X1 = 7'($urandom);
                FILL_Y1 = 6'($urandom); FILL_COLOR = 8'($urandom);
            end
            step();
            if (cpu) begin
                exp = {1'b1, wa, wd, 1'b1, 1'b0};
            end else begin
                a = q.pop_front();
                exp = {1'b1, a, 8'(color), 1'b1, (q.size() == 0)};
            end
            obs = {FB_WE, FB_WE ? FB_WA : 13'h0, FB_WE ? FB_WD : 8'h0, FILL_BUSY, FILL_DONE};
            n_total++;
            if (obs !== exp) $display("FAIL %s cyc%0d got=%h exp=%h", name, i, obs, exp);
            else n_pass++;
            i++;
        end
        CPU_WE = 1'b0;
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL %s timeout got=%0d_left exp=0_left", name, q.size());
        end

        // START during DONE (or the empty-rect DONE cycle) must not launch a fill.
        FILL_START = 1'b1; FILL_X0 = 7'd0; FILL_Y0 = 6'd0; FILL_X1 = 7'd1; FILL_Y1 = 6'd0;
        step();
        FILL_START = 1'b0;
        obs = {FB_WE, FILL_BUSY, FILL_DONE};
        n_total++;
        if (obs !== 3'b000) $display("FAIL %s after_done got=%b exp=000", name, obs);
        else n_pass++;
    endtask

    task automatic test_fill_2x2();
        run_fill("fill_2x2", 3, 4, 4, 5, 8'h1C, 0, -1, -1);
    endtask

    task automatic test_collision();
        run_fill("collision", 3, 4, 4, 5, 8'h1C, 0, 1, -1);
    endtask

    task automatic test_clamp_empty();
        run_fill("clamp", 78, 59, 100, 59, 8'h03, 0, -1, -1);
        run_fill("empty_x", 10, 5, 5, 8, 8'h44, 0, -1, -1);
        run_fill("empty_y", 0, 63, 3, 63, 8'h44, 0, -1, -1);
        run_fill("corner", 79, 59, 127, 63, 8'h99, 0, -1, -1);
    endtask

    task automatic test_random_fills();
        int x0, y0, x1, y1;
        for (int n = 0; n < 25; n++) begin
            x0 = int'($urandom_range(85));
            y0 = int'($urandom_range(61));
            x1 = x0 + int'($urandom_range(14)) - 3;
            y1 = y0 + int'($urandom_range(6)) - 1;
            if (x1 < 0) x1 = 0;
            if (x1 > 127) x1 = 127;
            if (y1 < 0) y1 = 0;
            if (y1 > 63) y1 = 63;
            run_fill("random", x0, y0, x1, y1, int'($urandom_range(255)), 25, -1, -1);
        end
    endtask

    task automatic test_busy_and_reset();
        run_fill("full_screen", 0, 0, 79, 59, 8'hA5, 10, -1, -1);
        run_fill("abort", 0, 0, 79, 59, 8'h5A, 5, -1, 300);
        run_fill("post_abort", 2, 2, 5, 3, 8'h77, 20, -1, -1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_back_to_back();
        test_fill_2x2();
        test_collision();
        test_clamp_empty();
        test_random_fills();
        test_busy_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_fb_write_arbiter.md
Name: vga_fb_write_arbiter

Overview:
- Owns the single write port (WA/WD/WE) of the 80x60 VGA framebuffer driver and shares it between two requesters.
  - CPU pixel writes decoded from the MMIO IOBUS.
  - A built-in rectangle-fill engine that clears or paints regions without a CPU loop.
- Sits between the IOBUS decode logic and the framebuffer driver, on the 50 MHz system clock domain.

Parameters:
- COLS, 80, visible columns; max legal x = COLS-1
- ROWS, 60, visible rows; max legal y = ROWS-1
- XW, 7, column field width in framebuffer address
- YW, 6, row field width in framebuffer address

Ports:
- CLK  in  1  system clock (50 MHz sclk domain)
- RST  in  1  synchronous, active-high reset
- CPU_WE  in  1  CPU pixel write strobe, one cycle per pixel
- CPU_WA  in  13  CPU pixel address {y[5:0], x[6:0]}
- CPU_WD  in  8  CPU pixel colour RRRGGGBB
- FILL_START  in  1  start a fill; sampled only in IDLE
- FILL_X0  in  7  left column, inclusive
- FILL_Y0  in  6  top row, inclusive
- FILL_X1  in  7  right column, inclusive
- FILL_Y1  in  6  bottom row, inclusive
- FILL_COLOR  in  8  fill colour
- FILL_BUSY  out  1  high while state != IDLE
- FILL_DONE  out  1  one-cycle pulse when a fill completes
- FB_WE  out  1  framebuffer write enable (registered)
- FB_WA  out  13  framebuffer address (registered)
- FB_WD  out  8  framebuffer data (registered)

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values:
  - FB_WE=0, FB_WA=0, FB_WD=0.
  - FILL_BUSY=0, FILL_DONE=0.
  - state=IDLE; internal x/y counters 0.
- Address format: {y, x}, i.e. addr = y*128 + x. Columns 80..127 are never written by the fill engine.
- Registered outputs: FB_* registered; FB_WE defaults to 0 every cycle.
- Arbitration: the CPU has absolute priority.
  - Any cycle with CPU_WE=1, in any state: FB_WE<=1, FB_WA<=CPU_WA, FB_WD<=CPU_WD.
  - Latency is 1 cycle. CPU writes are never dropped or delayed.
- States: IDLE, FILL, DONE.
- IDLE:
  - On FILL_START=1, latch colour, X0, Y0, X1c=min(X1,COLS-1), Y1c=min(Y1,ROWS-1).
  - If X0>X1c or Y0>Y1c: go to DONE with no writes (empty rect).
  - Otherwise set x=X0, y=Y0 and go to FILL.
- FILL, each cycle:
  - If CPU_WE=1: stall (no fill write, counters hold).
  - Else: FB_WE<=1, FB_WA<={y,x}, FB_WD<=colour, then advance the counters.
    - If x==X1c: x<=X0, y<=y+1.
    - Else: x<=x+1.
  - When the issued pixel is (X1c,Y1c): go to DONE.
- DONE: FILL_DONE=1 for exactly this cycle, then go to IDLE.
  - For a non-empty fill, DONE coincides with the cycle FB_WE shows the last pixel.
- Order and count: row-major, left to right, top to bottom. Pixel count = (X1c-X0+1)*(Y1c-Y0+1).
- FILL_BUSY = (state != IDLE), combinational from state.
- FILL_START while in FILL or DONE: ignored. No queuing and no restart.
- Fill inputs are sampled only at start; later changes to FILL_* have no effect.
- RST mid-fill: abort immediately, return to reset values, no FILL_DONE pulse.
- RST and CPU_WE in the same cycle: reset wins, FB_WE=0.
- Counter wrap is impossible by construction: y never exceeds Y1c ≤ 59, x never exceeds X1c ≤ 79.

Test Plan:
- Reset plus CPU write:
  - Stimulus: assert RST 2 cycles; then CPU_WE=1, WA=0x0203, WD=0xE0 for 1 cycle.
  - Response: all outputs 0 during reset; FB_WE=1, FB_WA=0x0203, FB_WD=0xE0 the next cycle only.
- 2x2 fill:
  - Stimulus: X0=3, Y0=4, X1=4, Y1=5, COLOR=0x1C, START 1 cycle.
  - Response: FB_WA sequence 515, 516, 643, 644 on consecutive cycles, FB_WD=0x1C. FILL_DONE high with the 644 write. FILL_BUSY high from the cycle after START through DONE.
- Collision:
  - Stimulus: during the same 2x2 fill, CPU_WE=1 (WA=0x0000, WD=0xFF) in the cycle the 516 write would be issued.
  - Response: FB shows 515, 0x0000/0xFF, 516, 643, 644. No pixel skipped or duplicated; DONE delayed by 1 cycle.
- Clamp and empty:
  - Stimulus A: X0=78, X1=100, Y0=Y1=59.
  - Response A: writes 7630 and 7631 only.
  - Stimulus B: X0=10, X1=5.
  - Response B: zero writes; FILL_DONE pulses 1 cycle after START.
- Busy and reset:
  - Stimulus: full-screen fill (0,0)-(79,59) expecting 4800 writes; pulse START again mid-fill; later assert RST.
  - Response: the second START is ignored. RST forces FB_WE=0 and FILL_BUSY=0 on the next cycle, with no FILL_DONE. A subsequent START works normally.
